zap_mem_arbiter: RTL and testbench
==================================

ZAP_MEM_ARBITER -- requirements
Module: zap_mem_arbiter

Interface
REQ-001 Parameter NUM_CH, default 2: number of requester channels (2..8).
REQ-002 Parameter ADDR_WDT, default 32: address width.
REQ-003 Parameter DATA_WDT, default 32: data width; byte-enable width is DATA_WDT/8.
REQ-004 i_clk  input  1  the single clock; all state on rising edge.
REQ-005 i_reset  input  1  asynchronous, active-high reset.
REQ-006 i_rd_en  input  NUM_CH  per-channel read request.
REQ-007 i_wr_en  input  NUM_CH  per-channel write request.
REQ-008 i_addr  input  NUM_CH*ADDR_WDT  per-channel address; channel k at slice k.
REQ-009 i_wdata  input  NUM_CH*DATA_WDT  per-channel write data.
REQ-010 i_ben  input  NUM_CH*DATA_WDT/8  per-channel byte enables.
REQ-011 o_ack  output  NUM_CH  one-cycle completion pulse, one-hot.
REQ-012 o_rdata  output  DATA_WDT  read data, valid while o_ack nonzero.
REQ-013 o_busy  output  1  high in ACTIVE and DONE.
REQ-014 o_ram_rd_en, o_ram_wr_en  output  1 each  RAM commands.
REQ-015 o_ram_addr, o_ram_data, o_ram_ben  output  ADDR_WDT, DATA_WDT, DATA_WDT/8  RAM address, write data, byte enables.
REQ-016 i_ram_rdata  input  DATA_WDT  RAM read data.
REQ-017 i_ram_stall  input  1  RAM not done; high holds the current command.

Function
REQ-018 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-019 FSM states SHALL be IDLE, ACTIVE and DONE.
REQ-020 Channel k requests when i_rd_en[k] | i_wr_en[k]; the requester SHALL hold the request and its operands stable until o_ack[k].
REQ-021 IDLE with at least one request: the arbiter SHALL latch the winner's addr/wdata/ben/command into the o_ram_* registers, record the grant, and go to ACTIVE; IDLE with no requests: remain in IDLE.
REQ-022 ACTIVE: o_ram_* SHALL hold unchanged while i_ram_stall=1; on a clock edge with i_ram_stall=0, the arbiter SHALL capture i_ram_rdata into o_rdata, set o_ack[grant]=1, clear o_ram_rd_en/o_ram_wr_en, and go to DONE.
REQ-023 DONE: requests SHALL be ignored, o_ack SHALL clear on the next edge, and the FSM SHALL return to IDLE, so the requester has one cycle to drop its request.
REQ-024 Zero-stall latency SHALL be: request seen in IDLE at cycle N, RAM command in cycle N+1, o_ack in cycle N+2, IDLE again in cycle N+3.
REQ-025 If i_rd_en[k] and i_wr_en[k] are both high, the arbiter SHALL issue a write only (o_ram_rd_en=0).
REQ-026 For a write completion, o_rdata SHALL still load i_ram_rdata; its value is don't-care for writes.
REQ-027 Requests that change during ACTIVE or DONE SHALL NOT affect the latched command.
REQ-028 o_ram_addr, o_ram_data and o_ram_ben SHALL retain their last values in IDLE and DONE; only the enables drop.

Reset
REQ-029 Asserting i_reset at any time, including mid-transaction, SHALL immediately force IDLE, all outputs to 0, and the grant pointer to NUM_CH-1.
REQ-030 An in-flight RAM transaction cut by reset SHALL be abandoned with no o_ack.

Configuration
REQ-031 Macro ZAP_ARB_RR_EN selects the arbitration policy.
REQ-032 With ZAP_ARB_RR_EN defined: round-robin; the search SHALL start at (last_grant+1) mod NUM_CH, and last_grant SHALL update on each IDLE->ACTIVE transition.
REQ-033 Without ZAP_ARB_RR_EN: fixed priority; the lowest-index requesting channel SHALL win, and the pointer register SHALL be absent.

Verification
REQ-034 NUM_CH=2, ch0 read addr 0x100, i_ram_stall=0, i_ram_rdata=0xDEADBEEF -> o_ram_rd_en high for exactly 1 cycle with addr 0x100; o_ack=2'b01 with o_rdata=0xDEADBEEF two cycles after the request.
REQ-035 ch1 write addr 0x40, data 0x12345678, ben 4'b0011, i_ram_stall high for 3 cycles -> o_ram_wr_en/addr/data/ben stable for 4 cycles; o_ack=2'b10 one cycle after stall drops.
REQ-036 RR build, ch0 and ch1 requesting continuously for 4 transactions -> grant order 0,1,0,1; fixed build -> 0,0,0,0.
REQ-037 ch0 sets i_rd_en and i_wr_en together -> write issued, o_ram_rd_en=0.
REQ-038 i_reset pulsed while ACTIVE with stall high -> all outputs 0 immediately, no o_ack; after release, ch0 is granted first when both channels request.
REQ-039 ch0 keeps its request high through DONE, then drops it -> no duplicate transaction; IDLE sees the request low.

Source files
------------

// File: rtl/zap_mem_arbiter.sv
// Multi-channel memory arbiter: grants one requester at a time onto a single RAM port.
// Policy: fixed priority by default; define ZAP_ARB_RR_EN for round-robin.
module zap_mem_arbiter #(
  parameter int NUM_CH   = 2,
  parameter int ADDR_WDT = 32,
  parameter int DATA_WDT = 32
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic [NUM_CH-1:0]              i_rd_en,
  input  logic [NUM_CH-1:0]              i_wr_en,
  input  logic [NUM_CH*ADDR_WDT-1:0]     i_addr,
  input  logic [NUM_CH*DATA_WDT-1:0]     i_wdata,
  input  logic [NUM_CH*(DATA_WDT/8)-1:0] i_ben,
  output logic [NUM_CH-1:0]              o_ack,
  output logic [DATA_WDT-1:0]            o_rdata,
  output logic                           o_busy,
  output logic                           o_ram_rd_en,
  output logic                           o_ram_wr_en,
  output logic [ADDR_WDT-1:0]            o_ram_addr,
  output logic [DATA_WDT-1:0]            o_ram_data,
  output logic [DATA_WDT/8-1:0]          o_ram_ben,
  input  logic [DATA_WDT-1:0]            i_ram_rdata,
  input  logic                           i_ram_stall,
  output logic [1:0]                     o_state
);

  localparam int BEN_WDT = DATA_WDT / 8;
  localparam int CW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Handshake: channel k holds rd/wr request and operands stable until o_ack[k]
  // pulses; o_ack lasts one cycle (DONE), during which the request may be dropped.
  state_t            state;
  logic [NUM_CH-1:0] req;
  logic [CW-1:0]     win;
  logic [CW-1:0]     gnt;

  assign req     = i_rd_en | i_wr_en;
  assign o_state = state;

`ifdef ZAP_ARB_RR_EN
  logic [CW-1:0] last_grant;
  int            rr_idx;
  logic          found;

  // Search starts one past the previous winner and wraps.
  always_comb begin
    win    = '0;
    found  = 1'b0;
    rr_idx = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      rr_idx = (int'(last_grant) + i) % NUM_CH;
      if (!found && req[rr_idx]) begin
        win   = CW'(rr_idx);
        found = 1'b1;
      end
    end
  end
`else
  always_comb begin
    win = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i]) win = CW'(i);
    end
  end
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= IDLE;
      gnt         <= '0;
      o_ack       <= '0;
      o_rdata     <= '0;
      o_busy      <= 1'b0;
      o_ram_rd_en <= 1'b0;
      o_ram_wr_en <= 1'b0;
      o_ram_addr  <= '0;
      o_ram_data  <= '0;
      o_ram_ben   <= '0;
`ifdef ZAP_ARB_RR_EN
      last_grant  <= CW'(NUM_CH - 1);
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            gnt         <= win;
            o_ram_addr  <= i_addr[win*ADDR_WDT +: ADDR_WDT];
            o_ram_data  <= i_wdata[win*DATA_WDT +: DATA_WDT];
            o_ram_ben   <= i_ben[win*BEN_WDT +: BEN_WDT];
            // A simultaneous read+write request is served as a write.
            o_ram_wr_en <= i_wr_en[win];
            o_ram_rd_en <= i_rd_en[win] & ~i_wr_en[win];
            o_busy      <= 1'b1;
            state       <= ACTIVE;
`ifdef ZAP_ARB_RR_EN
            last_grant  <= win;
`endif
          end
        end
        ACTIVE: begin
          if (!i_ram_stall) begin
            o_rdata     <= i_ram_rdata;
            o_ack       <= {{(NUM_CH-1){1'b0}}, 1'b1} << gnt;
            o_ram_rd_en <= 1'b0;
            o_ram_wr_en <= 1'b0;
            state       <= DONE;
          end
        end
        DONE: begin
          o_ack  <= '0;
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          o_ack       <= '0;
          o_busy      <= 1'b0;
          o_ram_rd_en <= 1'b0;
          o_ram_wr_en <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zap_mem_arbiter.sv
// Self-checking bench for zap_mem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level arbitration model.
module tb_zap_mem_arbiter;

  localparam int NCH = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BW  = DW / 8;
`ifdef ZAP_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NCH-1:0]    rd_en, wr_en;
  logic [NCH*AW-1:0] addr;
  logic [NCH*DW-1:0] wdata;
  logic [NCH*BW-1:0] ben;
  logic [NCH-1:0]    ack;
  logic [DW-1:0]     rdata;
  logic              busy, ram_rd_en, ram_wr_en;
  logic [AW-1:0]     ram_addr;
  logic [DW-1:0]     ram_data;
  logic [BW-1:0]     ram_ben;
  logic [DW-1:0]     ram_rdata;
  logic              ram_stall;
  logic [1:0]        state;

  zap_mem_arbiter #(.NUM_CH(NCH), .ADDR_WDT(AW), .DATA_WDT(DW)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_rd_en(rd_en), .i_wr_en(wr_en), .i_addr(addr), .i_wdata(wdata), .i_ben(ben),
    .o_ack(ack), .o_rdata(rdata), .o_busy(busy),
    .o_ram_rd_en(ram_rd_en), .o_ram_wr_en(ram_wr_en),
    .o_ram_addr(ram_addr), .o_ram_data(ram_data), .o_ram_ben(ram_ben),
    .i_ram_rdata(ram_rdata), .i_ram_stall(ram_stall), .o_state(state)
  );

  // scoreboard
  int total = 0;
  int bad   = 0;
  int last_grant;
  logic [NCH-1:0] exp_q[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic set_req(input int ch, input bit rd, input bit wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] b);
    rd_en[ch] = rd;
    wr_en[ch] = wr;
    addr[ch*AW +: AW]  = a;
    wdata[ch*DW +: DW] = d;
    ben[ch*BW +: BW]   = b;
  endtask

  task automatic clr_req(input int ch);
    rd_en[ch] = 1'b0;
    wr_en[ch] = 1'b0;
  endtask

  task automatic rand_req(input int ch);
    int op;
    op = $urandom_range(0, 2);
    set_req(ch, op != 1, op != 0, $urandom, $urandom, BW'($urandom));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"}, ack, 0);
    check({tag, "_rdata"}, rdata, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_en"}, {ram_rd_en, ram_wr_en}, 0);
    check({tag, "_cmd"}, {ram_addr, ram_data, ram_ben}, 0);
    check({tag, "_state"}, state, 0);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    rd_en = '0; wr_en = '0; ram_stall = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    last_grant = NCH - 1;
    exp_q.delete();
  endtask

  // reference model: choose the winner from the current request set by policy rules
  function automatic int model_pick();
    logic [NCH-1:0] r;
    r = rd_en | wr_en;
    if (RR) begin
      for (int i = 1; i <= NCH; i++)
        if (r[(last_grant + i) % NCH]) return (last_grant + i) % NCH;
    end else begin
      for (int c = 0; c < NCH; c++)
        if (r[c]) return c;
    end
    return -1;
  endfunction

  // Called in an idle cycle with requests applied; returns in the following idle
  // cycle with the winner's request dropped.
  task automatic run_txn(input int stall, input logic [DW-1:0] rv, input bit perturb, output int w);
    logic [AW-1:0]  ea;
    logic [DW-1:0]  ed;
    logic [BW-1:0]  eb;
    logic           ewr, erd;
    logic [NCH-1:0] oh;
    w = model_pick();
    if (w < 0) begin
      check("pick_none", 1, 0);
      return;
    end
    ea  = addr[w*AW +: AW];
    ed  = wdata[w*DW +: DW];
    eb  = ben[w*BW +: BW];
    ewr = wr_en[w];
    erd = rd_en[w] & ~wr_en[w];
    last_grant = w;
    oh = '0;
    oh[w] = 1'b1;
    exp_q.push_back(oh);
    ram_stall = (stall > 0);
    ram_rdata = $urandom;
    tick();
    check("cmd_en", {ram_rd_en, ram_wr_en}, {erd, ewr});
    check("cmd_addr", ram_addr, ea);
    check("cmd_data", {ram_data, ram_ben}, {ed, eb});
    check("act_busy_ack", {busy, ack}, {1'b1, {NCH{1'b0}}});
    for (int s = 0; s < stall; s++) begin
      ram_rdata = $urandom;
      if (perturb)
        for (int c = 0; c < NCH; c++)
          if (c != w && !(rd_en[c] | wr_en[c]) && $urandom_range(0, 1) == 1) rand_req(c);
      tick();
      check("hold_en", {ram_rd_en, ram_wr_en}, {erd, ewr});
      check("hold_cmd", {ram_addr, ram_data, ram_ben}, {ea, ed, eb});
      check("hold_ack", ack, 0);
    end
    ram_stall = 1'b0;
    ram_rdata = rv;
    tick();
    check("done_ack", ack, exp_q.pop_front());
    check("done_rdata", rdata, rv);
    check("done_en", {ram_rd_en, ram_wr_en}, 0);
    check("done_keep", {ram_addr, ram_data, ram_ben, busy}, {ea, ed, eb, 1'b1});
    tick();
    check("idle_ack_busy", {ack, busy}, 0);
    check("idle_keep", {ram_rd_en, ram_wr_en, ram_addr, ram_data, ram_ben}, {2'b00, ea, ed, eb});
    clr_req(w);
  endtask

  initial begin
    int w;
    rd_en = '0; wr_en = '0; addr = '0; wdata = '0; ben = '0;
    ram_rdata = '0; ram_stall = 1'b0; rst = 1'b0;
    #2;
    reset_dut();

    // ch0 read, no stall
    set_req(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
    run_txn(0, 32'hDEADBEEF, 1'b0, w);
    check("rd0_grant", w, 0);

    // ch1 write, 3 stall cycles
    set_req(1, 1'b0, 1'b1, 32'h40, 32'h12345678, 4'b0011);
    run_txn(3, 32'h0, 1'b0, w);
    check("wr1_grant", w, 1);

    // read+write together -> write only
    set_req(0, 1'b1, 1'b1, 32'h200, 32'hCAFEF00D, 4'b1111);
    run_txn(1, 32'h5A5A5A5A, 1'b0, w);

    // request kept through DONE, dropped in IDLE: no second transaction
    set_req(0, 1'b1, 1'b0, 32'h300, 32'h0, 4'hF);
    run_txn(0, 32'h11112222, 1'b0, w);
    tick();
    check("no_dup", {ram_rd_en, ram_wr_en, busy, ack}, 0);

    // continuous requests from both channels
    reset_dut();
    set_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    set_req(1, 1'b0, 1'b1, 32'h20, 32'h99, 4'h1);
    for (int k = 0; k < 4; k++) begin
      run_txn(0, $urandom, 1'b0, w);
      check("order", w, RR ? (k % 2) : 0);
      if (w == 0) set_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
      else        set_req(1, 1'b0, 1'b1, 32'h20, 32'h99, 4'h1);
    end
    clr_req(0);
    clr_req(1);

    // reset in the middle of a stalled transaction
    set_req(1, 1'b0, 1'b1, 32'h80, 32'h77, 4'h3);
    ram_stall = 1'b1;
    tick();
    check("pre_rst_wr", ram_wr_en, 1);
    rst = 1'b1;
    #1;
    check_all_zero("mid_rst");
    tick();
    check("rst_ack", ack, 0);
    rst = 1'b0;
    ram_stall = 1'b0;
    last_grant = NCH - 1;
    exp_q.delete();
    set_req(0, 1'b1, 1'b0, 32'h90, 32'h0, 4'hF);
    run_txn(0, $urandom, 1'b0, w);
    check("rst_first", w, 0);
    run_txn(0, $urandom, 1'b0, w);
    check("rst_second", w, 1);

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      for (int c = 0; c < NCH; c++)
        if (!(rd_en[c] | wr_en[c]) && $urandom_range(0, 1) == 1) rand_req(c);
      if ((rd_en | wr_en) == '0) rand_req($urandom_range(0, NCH - 1));
      run_txn($urandom_range(0, 3), $urandom, 1'b1, w);
    end

    check("exp_q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
